// File: rtl/timer_tick_sequencer_pkg.sv
// Shared types for the mm:ss timer datapath: FSM states, BCD digit types and
// the top value of a seconds (or minutes) field.
// Optional build macro used by the top: TIMER_BLINK_EN.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    RUN,
    HOLD,
    EXPIRED
  } state_t;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [2:0] bcd_tens_t;

  localparam int BCD_TOP_59 = 59;

  function automatic logic bcd_is_zero(input bcd_tens_t tens, input bcd_digit_t ones);
    return (tens == 3'd0) && (ones == 4'd0);
  endfunction

endpackage

// File: rtl/timer_tick_sequencer_bcd_mod60_counter.sv
// Two-digit BCD counter that wraps between 00 and a configurable top value.
// Increment wraps top -> 00, decrement wraps 00 -> top and raises o_borrow in
// the same cycle so a higher field can decrement on the same clock edge.
module bcd_mod60_counter
  import timer_pkg::*;
#(
  parameter int TOP = BCD_TOP_59
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_inc,
  input  logic       i_dec,
  output bcd_digit_t o_ones,
  output bcd_tens_t  o_tens,
  output logic       o_borrow
);

  localparam bcd_tens_t  TOP_TENS = bcd_tens_t'(TOP / 10);
  localparam bcd_digit_t TOP_ONES = bcd_digit_t'(TOP % 10);

  bcd_digit_t r_ones;
  bcd_tens_t  r_tens;
  logic       w_at_zero;
  logic       w_at_top;

  assign w_at_zero = bcd_is_zero(r_tens, r_ones);
  assign w_at_top  = (r_tens == TOP_TENS) && (r_ones == TOP_ONES);
  assign o_borrow  = i_dec & ~i_inc & ~i_clear & w_at_zero;
  assign o_ones    = r_ones;
  assign o_tens    = r_tens;

  // Clear wins, then increment, then decrement; each step stays in BCD range.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_ones <= 4'd0;
      r_tens <= 3'd0;
    end else if (i_inc) begin
      if (w_at_top) begin
        r_ones <= 4'd0;
        r_tens <= 3'd0;
      end else if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 3'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end else if (i_dec) begin
      if (w_at_zero) begin
        r_ones <= TOP_ONES;
        r_tens <= TOP_TENS;
      end else if (r_ones == 4'd0) begin
        r_ones <= 4'd9;
        r_tens <= r_tens - 3'd1;
      end else begin
        r_ones <= r_ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/timer_tick_sequencer.sv
// mm:ss countdown timer datapath. Divides the system clock into count ticks,
// applies edge-detected set increments, counts down in BCD and flags expiry.
// Build macro TIMER_BLINK_EN: when defined, blink toggles on every prescaler
// wrap while expired; when undefined blink is constant 0.
module timer_tick_sequencer
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_counter,
  input  logic       forward,
  input  logic       reset_timer,
  input  logic       seg_demand,
  input  logic       min_demand,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       tick,
  output logic       expired,
  output logic       blink
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_seg_prev;
  logic          r_min_prev;
  logic          r_tick;
  logic          r_expired;
  logic          r_blink;

  logic       w_set_mode;
  logic       w_run_mode;
  logic       w_seg_pulse;
  logic       w_min_pulse;
  logic       w_wrap;
  logic       w_sec_inc;
  logic       w_min_inc;
  logic       w_sec_borrow;
  logic       w_min_borrow;
  logic       w_value_zero;
  logic       w_value_last;
  bcd_digit_t w_sec_ones;
  bcd_tens_t  w_sec_tens;
  bcd_digit_t w_min_ones;
  bcd_tens_t  w_min_tens;

  assign w_set_mode  = enable_counter & forward;
  assign w_run_mode  = enable_counter & ~forward;
  assign w_seg_pulse = seg_demand & ~r_seg_prev;
  assign w_min_pulse = min_demand & ~r_min_prev;
  assign w_wrap      = (r_state == RUN) & w_run_mode & (r_presc == PRESC_LAST) & ~reset_timer;
  assign w_sec_inc   = (r_state == SET) & w_seg_pulse;
  assign w_min_inc   = (r_state == SET) & w_min_pulse;

  assign w_value_zero = bcd_is_zero(w_min_tens, w_min_ones) && bcd_is_zero(w_sec_tens, w_sec_ones);
  assign w_value_last = bcd_is_zero(w_min_tens, w_min_ones) && (w_sec_tens == 3'd0) && (w_sec_ones == 4'd1);

  bcd_mod60_counter #(
    .TOP(BCD_TOP_59)
  ) u_seconds (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (reset_timer),
    .i_inc   (w_sec_inc),
    .i_dec   (w_wrap),
    .o_ones  (w_sec_ones),
    .o_tens  (w_sec_tens),
    .o_borrow(w_sec_borrow)
  );

  bcd_mod60_counter #(
    .TOP(MAX_MIN)
  ) u_minutes (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (reset_timer),
    .i_inc   (w_min_inc),
    .i_dec   (w_sec_borrow),
    .o_ones  (w_min_ones),
    .o_tens  (w_min_tens),
    .o_borrow(w_min_borrow)
  );

  assign sec_ones = w_sec_ones;
  assign sec_tens = w_sec_tens;
  assign min_ones = w_min_ones;
  assign min_tens = w_min_tens;
  assign tick     = r_tick;
  assign expired  = r_expired;
  assign blink    = r_blink;

  // Control FSM with prescaler, demand edge registers and registered flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_presc    <= '0;
      r_seg_prev <= 1'b0;
      r_min_prev <= 1'b0;
      r_tick     <= 1'b0;
      r_expired  <= 1'b0;
      r_blink    <= 1'b0;
    end else begin
      r_seg_prev <= seg_demand;
      r_min_prev <= min_demand;
      if (reset_timer) begin
        r_state   <= IDLE;
        r_presc   <= '0;
        r_tick    <= 1'b0;
        r_expired <= 1'b0;
        r_blink   <= 1'b0;
      end else begin
        case (r_state)
          IDLE, SET, HOLD: begin
            r_tick    <= 1'b0;
            r_expired <= 1'b0;
            r_blink   <= 1'b0;
            if (w_set_mode) begin
              r_state <= SET;
              r_presc <= '0;
            end else if (w_run_mode) begin
              if (w_value_zero) begin
                r_state   <= EXPIRED;
                r_expired <= 1'b1;
                r_presc   <= '0;
              end else begin
                r_state <= RUN;
              end
            end
          end
          RUN: begin
            r_expired <= 1'b0;
            r_blink   <= 1'b0;
            if (!enable_counter) begin
              r_state <= HOLD;
              r_tick  <= 1'b0;
            end else if (forward) begin
              r_state <= SET;
              r_presc <= '0;
              r_tick  <= 1'b0;
            end else if (r_presc == PRESC_LAST) begin
              r_presc <= '0;
              r_tick  <= 1'b1;
              if (w_value_last || w_min_borrow) begin
                r_state   <= EXPIRED;
                r_expired <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
              r_tick  <= 1'b0;
            end
          end
          EXPIRED: begin
            r_tick    <= 1'b0;
            r_expired <= 1'b1;
`ifdef TIMER_BLINK_EN
            if (r_presc == PRESC_LAST) begin
              r_presc <= '0;
              r_blink <= ~r_blink;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
`else
            r_blink <= 1'b0;
`endif
          end
          default: begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_expired <= 1'b0;
            r_blink   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// Directed bench for timer_tick_sequencer with CLK_HZ=4, TICK_HZ=1 (DIV=4).
// Expectations are queued with a due cycle and checked when that cycle comes.
// Honours TIMER_BLINK_EN for the blink expectations.
module tb_timer_tick_sequencer;

  localparam int CLK_HZ  = 4;
  localparam int TICK_HZ = 1;
  localparam int MAX_MIN = 59;
`ifdef TIMER_BLINK_EN
  localparam logic BLINK_BUILD = 1'b1;
`else
  localparam logic BLINK_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_counter;
  logic       forward;
  logic       reset_timer;
  logic       seg_demand;
  logic       min_demand;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic       tick;
  logic       expired;
  logic       blink;

  typedef struct {
    int          due;
    string       tag;
    logic [13:0] value;
    logic        tick;
    logic        expired;
    logic        blink;
  } exp_t;

  exp_t sbQ[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  timer_tick_sequencer #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .MAX_MIN(MAX_MIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_counter(enable_counter),
    .forward       (forward),
    .reset_timer   (reset_timer),
    .seg_demand    (seg_demand),
    .min_demand    (min_demand),
    .sec_ones      (sec_ones),
    .sec_tens      (sec_tens),
    .min_ones      (min_ones),
    .min_tens      (min_tens),
    .tick          (tick),
    .expired       (expired),
    .blink         (blink)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  function automatic logic [13:0] bcd(input int mm, input int ss);
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [13:0] obs;
    obs = {min_tens, min_ones, sec_tens, sec_ones};
    checks++;
    assert (obs === e.value) else begin
      errors++;
      $error("FAIL %s value: observed %0d%0d:%0d%0d expected %0d%0d:%0d%0d", e.tag,
             obs[13:11], obs[10:7], obs[6:4], obs[3:0],
             e.value[13:11], e.value[10:7], e.value[6:4], e.value[3:0]);
    end
    checks++;
    assert (tick === e.tick) else begin
      errors++;
      $error("FAIL %s tick: observed %b expected %b", e.tag, tick, e.tick);
    end
    checks++;
    assert (expired === e.expired) else begin
      errors++;
      $error("FAIL %s expired: observed %b expected %b", e.tag, expired, e.expired);
    end
    checks++;
    assert (blink === e.blink) else begin
      errors++;
      $error("FAIL %s blink: observed %b expected %b", e.tag, blink, e.blink);
    end
  endtask

  task automatic expectIn(input int dly, input string tag, input int mm, input int ss,
                          input logic tk, input logic ex, input logic bl);
    exp_t e;
    e.due     = cyc + dly;
    e.tag     = tag;
    e.value   = bcd(mm, ss);
    e.tick    = tk;
    e.expired = ex;
    e.blink   = bl;
    sbQ.push_back(e);
  endtask

  task automatic cycle();
    int i;
    @(posedge clk);
    #1;
    cyc++;
    i = 0;
    while (i < sbQ.size()) begin
      if (sbQ[i].due == cyc) begin
        checkOutput(sbQ[i]);
        sbQ.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic applyStimulus(input logic en, input logic fwd, input logic rt,
                               input logic seg, input logic mn);
    enable_counter = en;
    forward        = fwd;
    reset_timer    = rt;
    seg_demand     = seg;
    min_demand     = mn;
  endtask

  task automatic pulseDemand(input logic seg, input logic mn, input int n);
    repeat (n) begin
      seg_demand = seg;
      min_demand = mn;
      cycle();
      seg_demand = 1'b0;
      min_demand = 1'b0;
      cycle();
    end
  endtask

  task automatic clearAndSet(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expectIn(1, tag, 0, 0, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expectIn(2, "reset", 0, 0, 1'b0, 1'b0, 1'b0);
    cycles(2);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    pulseDemand(1'b1, 1'b0, 3);
    pulseDemand(1'b0, 1'b1, 1);
    expectIn(1, "set_0103", 1, 3, 1'b0, 1'b0, 1'b0);
    cycle();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expectIn(1,  "run_enter",    1, 3,  1'b0, 1'b0, 1'b0);
    expectIn(4,  "run_pre_tick", 1, 3,  1'b0, 1'b0, 1'b0);
    expectIn(5,  "run_t1",       1, 2,  1'b1, 1'b0, 1'b0);
    expectIn(6,  "run_t1_end",   1, 2,  1'b0, 1'b0, 1'b0);
    expectIn(9,  "run_t2",       1, 1,  1'b1, 1'b0, 1'b0);
    expectIn(13, "run_t3",       1, 0,  1'b1, 1'b0, 1'b0);
    expectIn(17, "run_t4",       0, 59, 1'b1, 1'b0, 1'b0);
    cycles(17);

    clearAndSet("clear_exp");
    pulseDemand(1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expectIn(1,  "exp_run_enter", 0, 2, 1'b0, 1'b0, 1'b0);
    expectIn(5,  "exp_tick1",     0, 1, 1'b1, 1'b0, 1'b0);
    expectIn(8,  "exp_pre_last",  0, 1, 1'b0, 1'b0, 1'b0);
    expectIn(9,  "exp_final",     0, 0, 1'b1, 1'b1, 1'b0);
    expectIn(10, "exp_tick_clr",  0, 0, 1'b0, 1'b1, 1'b0);
    expectIn(12, "exp_blink_pre", 0, 0, 1'b0, 1'b1, 1'b0);
    expectIn(13, "exp_blink1",    0, 0, 1'b0, 1'b1, BLINK_BUILD);
    expectIn(17, "exp_blink2",    0, 0, 1'b0, 1'b1, 1'b0);
    expectIn(21, "exp_blink3",    0, 0, 1'b0, 1'b1, BLINK_BUILD);
    cycles(13);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycles(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expectIn(1, "exp_rt_exit", 0, 0, 1'b0, 1'b0, 1'b0);
    cycle();

    clearAndSet("clear_wrap");
    pulseDemand(1'b1, 1'b0, 59);
    expectIn(1, "sec_59", 0, 59, 1'b0, 1'b0, 1'b0);
    cycle();
    pulseDemand(1'b1, 1'b0, 1);
    expectIn(1, "sec_wrap", 0, 0, 1'b0, 1'b0, 1'b0);
    cycle();
    pulseDemand(1'b0, 1'b1, 59);
    expectIn(1, "min_59", 59, 0, 1'b0, 1'b0, 1'b0);
    cycle();
    pulseDemand(1'b0, 1'b1, 1);
    expectIn(1, "min_wrap", 0, 0, 1'b0, 1'b0, 1'b0);
    cycle();

    clearAndSet("clear_hold");
    pulseDemand(1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expectIn(3, "hold_run_p2", 2, 0, 1'b0, 1'b0, 1'b0);
    cycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expectIn(1,  "hold_enter", 2, 0, 1'b0, 1'b0, 1'b0);
    expectIn(11, "hold_10",    2, 0, 1'b0, 1'b0, 1'b0);
    cycles(11);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expectIn(2, "resume_p3",   2, 0,  1'b0, 1'b0, 1'b0);
    expectIn(3, "resume_tick", 1, 59, 1'b1, 1'b0, 1'b0);
    cycles(3);

    clearAndSet("clear_prio");
    pulseDemand(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expectIn(4, "prio_pre", 0, 5, 1'b0, 1'b0, 1'b0);
    cycles(4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    expectIn(1, "prio_rt", 0, 0, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expectIn(1, "zero_run_exp", 0, 0, 1'b0, 1'b1, 1'b0);
    cycle();

    rst_n = 1'b0;
    expectIn(1, "rstn_clear", 0, 0, 1'b0, 1'b0, 1'b0);
    cycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(2);

    checks++;
    assert (sbQ.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
